// File: rtl/pla_pipe_engine.sv
// Programmable two-level AND-OR plane evaluated over a 2-stage valid/ready pipeline.
// Term planes and output phase are loaded at run time while the pipe is empty.
module pla_pipe_engine #(
    parameter int N_IN    = 26,
    parameter int N_OUT   = 11,
    parameter int N_TERMS = 64,
    parameter int TW      = $clog2(N_TERMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [TW-1:0]      cfg_addr,
    input  logic [N_IN-1:0]    cfg_mask,
    input  logic [N_IN-1:0]    cfg_val,
    input  logic [N_OUT-1:0]   cfg_or,
    input  logic               cfg_en,
    input  logic               pol_we,
    input  logic [N_OUT-1:0]   pol_val,
    output logic               cfg_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_OUT-1:0]   out_z,
    output logic [N_TERMS-1:0] out_hits
);

    logic [N_IN-1:0]    r_mask [N_TERMS];
    logic [N_IN-1:0]    r_val  [N_TERMS];
    logic [N_OUT-1:0]   r_or   [N_TERMS];
    logic [N_TERMS-1:0] r_en;
    logic [N_OUT-1:0]   r_pol;

    logic               r_s1_valid;
    logic [N_TERMS-1:0] r_s1_hits;
    logic               r_out_valid;
    logic [N_OUT-1:0]   r_out_z;
    logic [N_TERMS-1:0] r_out_hits;

    logic               w_addr_ok;
    logic               w_cfg_wr;
    logic               w_pol_wr;
    logic               w_s1_load;
    logic               w_s2_load;
    logic [N_TERMS-1:0] w_hit;
    logic [N_OUT-1:0]   w_z;

    assign w_addr_ok = (32'(cfg_addr) < N_TERMS);
    assign cfg_ready = ~r_s1_valid & ~r_out_valid;
    assign w_cfg_wr  = cfg_we & cfg_ready & w_addr_ok;
    assign w_pol_wr  = pol_we & cfg_ready;

    // A pending config write blocks new vectors so none sees a half-written plane
    assign in_ready  = (~r_s1_valid | ~r_out_valid | out_ready)
                     & ~(cfg_ready & (cfg_we | pol_we));
    assign w_s1_load = in_valid & in_ready;
    assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);

    assign out_valid = r_out_valid;
    assign out_z     = r_out_z;
    assign out_hits  = r_out_hits;

    always_comb begin
        w_hit = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            w_hit[t] = r_en[t] & (&(~r_mask[t] | ~(in_x ^ r_val[t])));
        end
    end

    always_comb begin
        w_z = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (r_s1_hits[t]) begin
                w_z = w_z | r_or[t];
            end
        end
        w_z = w_z ^ r_pol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N_TERMS; t++) begin
                r_mask[t] <= '0;
                r_val[t]  <= '0;
                r_or[t]   <= '0;
            end
            r_en  <= '0;
            r_pol <= '0;
        end else begin
            if (w_cfg_wr) begin
                r_mask[cfg_addr] <= cfg_mask;
                r_val[cfg_addr]  <= cfg_val;
                r_or[cfg_addr]   <= cfg_or;
                r_en[cfg_addr]   <= cfg_en;
            end
            if (w_pol_wr) begin
                r_pol <= pol_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hits  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_hits  <= w_hit;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
            r_out_hits  <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_z     <= w_z;
            r_out_hits  <= r_s1_hits;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pla_pipe_engine.sv
// Directed bench for pla_pipe_engine: plane loading, phase mask, backpressure,
// config stalls, an espresso cube set and mid-stream reset.
module tb_pla_pipe_engine;

    localparam int N_IN    = 26;
    localparam int N_OUT   = 11;
    localparam int N_TERMS = 64;
    localparam int TW      = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [TW-1:0]      cfg_addr = '0;
    logic [N_IN-1:0]    cfg_mask = '0;
    logic [N_IN-1:0]    cfg_val = '0;
    logic [N_OUT-1:0]   cfg_or = '0;
    logic               cfg_en = 1'b0;
    logic               pol_we = 1'b0;
    logic [N_OUT-1:0]   pol_val = '0;
    logic               cfg_ready;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N_IN-1:0]    in_x = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [N_OUT-1:0]   out_z;
    logic [N_TERMS-1:0] out_hits;

    int passed = 0;
    int total  = 0;

    pla_pipe_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .TW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
        .cfg_val(cfg_val), .cfg_or(cfg_or), .cfg_en(cfg_en),
        .pol_we(pol_we), .pol_val(pol_val), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_hits(out_hits)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] model(input logic [3:0] x);
        logic [N_OUT-1:0] z;
        z = '0;
        z[0] = x[2] & x[1] & x[0] & ~x[3];
        z[1] = ~x[0] | x[3];
        z[2] = x[1] ^ x[2];
        z[3] = 1'b1;
        return z;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_we = 1'b0; pol_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_apply(input logic we, input logic pw,
                             input logic [TW-1:0] a, input logic [N_IN-1:0] m,
                             input logic [N_IN-1:0] v, input logic [N_OUT-1:0] o,
                             input logic en, input logic [N_OUT-1:0] pv);
        int k;
        cfg_we = we; pol_we = pw; cfg_addr = a; cfg_mask = m;
        cfg_val = v; cfg_or = o; cfg_en = en; pol_val = pv;
        k = 0;
        #1;
        while (!cfg_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        total++;
        if (k >= 50) $display("FAIL cfg_timeout: cfg_ready stayed 0 for %0d cycles, required 1", k);
        else passed++;
        @(negedge clk);
        cfg_we = 1'b0; pol_we = 1'b0;
    endtask

    task automatic run_vec(input logic [N_IN-1:0] x,
                           output logic [N_OUT-1:0] z,
                           output logic [N_TERMS-1:0] h);
        int k;
        in_valid = 1'b1; in_x = x;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk); k++;
        end
        z = out_z; h = out_hits;
        total++;
        if (k >= 10) $display("FAIL vec_timeout: no out_valid for x=%h, got 0 required 1", x);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready: got %b required 1", cfg_ready); else passed++;
        total++; if (out_z !== '0) $display("FAIL rst_out_z: got %h required 0", out_z); else passed++;
        total++; if (out_hits !== '0) $display("FAIL rst_out_hits: got %h required 0", out_hits); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_config();
        in_valid = 1'b1; in_x = 26'h3FFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL lat_early: out_valid got %b required 0", out_valid); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL lat_two: out_valid got %b required 1", out_valid); else passed++;
        total++; if (out_z !== 11'h000) $display("FAIL noconf_z: got %h required 000", out_z); else passed++;
        total++; if (out_hits !== '0) $display("FAIL noconf_hits: got %h required 0", out_hits); else passed++;
        @(negedge clk);
    endtask

    task automatic test_single_term();
        logic [N_OUT-1:0] z;
        logic [N_TERMS-1:0] h;
        cfg_apply(1'b1, 1'b0, 6'd0, 26'h4, 26'h0, 11'h001, 1'b1, 11'h0);
        run_vec(26'h3FFFFFB, z, h);
        total++; if (z !== 11'h001) $display("FAIL term_hit_z: got %h required 001", z); else passed++;
        total++; if (h !== 64'h1) $display("FAIL term_hit_hits: got %h required 1", h); else passed++;
        run_vec(26'h0000004, z, h);
        total++; if (z !== 11'h000) $display("FAIL term_miss_z: got %h required 000", z); else passed++;
        total++; if (h !== 64'h0) $display("FAIL term_miss_hits: got %h required 0", h); else passed++;
    endtask

    task automatic test_polarity();
        logic [N_OUT-1:0] z;
        logic [N_TERMS-1:0] h;
        do_reset();
        cfg_apply(1'b0, 1'b1, 6'd0, '0, '0, '0, 1'b0, 11'h7FF);
        run_vec(26'h1234567, z, h);
        total++; if (z !== 11'h7FF) $display("FAIL pol_only_z: got %h required 7ff", z); else passed++;
        total++; if (h !== 64'h0) $display("FAIL pol_only_hits: got %h required 0", h); else passed++;
        cfg_apply(1'b1, 1'b0, 6'd5, 26'h0, 26'h0, 11'h400, 1'b1, 11'h0);
        run_vec(26'h2AAAAAA, z, h);
        total++; if (z !== 11'h3FF) $display("FAIL pol_term_z: got %h required 3ff", z); else passed++;
        total++; if (h !== 64'h20) $display("FAIL pol_term_hits: got %h required 20", h); else passed++;
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        do_reset();
        for (int t = 0; t < 8; t++)
            cfg_apply(1'b1, 1'b0, TW'(t), 26'h7, 26'(t), 11'(1 << t), 1'b1, 11'h0);
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            out_ready = (cyc >= 8);
            in_valid = (sent < 8);
            in_x = 26'h2A5A5A0 | 26'(sent);
            #1;
            if (cyc == 6) begin
                total++; if (sent !== 2) $display("FAIL bp_accepts: got %0d required 2", sent); else passed++;
                total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready); else passed++;
                total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b required 1", out_valid); else passed++;
                total++; if (out_z !== 11'h001) $display("FAIL bp_hold_z: got %h required 001", out_z); else passed++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_z !== 11'(1 << got)) $display("FAIL b2b_z%0d: got %h required %h", got, out_z, 11'(1 << got));
                else passed++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== 8) $display("FAIL b2b_count: got %0d results required 8", got); else passed++;
        @(negedge clk);
    endtask

    task automatic test_cfg_stall();
        logic [N_OUT-1:0] res [2];
        logic [N_OUT-1:0] z;
        logic [N_TERMS-1:0] h;
        int nres;
        int k;
        do_reset();
        cfg_apply(1'b1, 1'b0, 6'd0, 26'h1, 26'h1, 11'h001, 1'b1, 11'h0);
        in_valid = 1'b1; in_x = 26'h1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_mask = 26'h1; cfg_val = 26'h1;
        cfg_or = 11'h002; cfg_en = 1'b1;
        #1;
        total++; if (cfg_ready !== 1'b0) $display("FAIL stall_cfg_ready: got %b required 0", cfg_ready); else passed++;
        nres = 0; k = 0;
        while (!cfg_ready && k < 20) begin
            if (out_valid && nres < 2) begin
                res[nres] = out_z; nres++;
            end
            @(negedge clk); #1; k++;
        end
        total++; if (nres !== 2) $display("FAIL stall_nres: got %0d required 2", nres); else passed++;
        total++; if (res[0] !== 11'h001) $display("FAIL stall_old0: got %h required 001", res[0]); else passed++;
        total++; if (res[1] !== 11'h001) $display("FAIL stall_old1: got %h required 001", res[1]); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL cfg_blocks_in: in_ready got %b required 0", in_ready); else passed++;
        @(negedge clk);
        cfg_we = 1'b0;
        run_vec(26'h1, z, h);
        total++; if (z !== 11'h002) $display("FAIL stall_new: got %h required 002", z); else passed++;
    endtask

    task automatic test_espresso();
        int sent;
        int got;
        logic [N_OUT-1:0] z;
        logic [N_TERMS-1:0] h;
        do_reset();
        cfg_apply(1'b1, 1'b0, 6'd0, 26'hF, 26'h7, 11'h001, 1'b1, 11'h0);
        cfg_apply(1'b1, 1'b0, 6'd1, 26'h1, 26'h0, 11'h002, 1'b1, 11'h0);
        cfg_apply(1'b1, 1'b0, 6'd2, 26'h8, 26'h8, 11'h002, 1'b1, 11'h0);
        cfg_apply(1'b1, 1'b0, 6'd3, 26'h6, 26'h2, 11'h004, 1'b1, 11'h0);
        cfg_apply(1'b1, 1'b0, 6'd4, 26'h6, 26'h4, 11'h004, 1'b1, 11'h0);
        cfg_apply(1'b0, 1'b1, 6'd0, '0, '0, '0, 1'b0, 11'h008);
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            in_valid = (sent < 16);
            in_x = {22'($urandom), 4'(sent)};
            #1;
            if (out_valid) begin
                total++;
                if (out_z !== model(4'(got))) $display("FAIL esp_x%0d: got %h required %h", got, out_z, model(4'(got)));
                else passed++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (got !== 16) $display("FAIL esp_count: got %0d required 16", got); else passed++;
        @(negedge clk);
        in_valid = 1'b1; in_x = 26'h7;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", out_valid); else passed++;
        total++; if (out_hits !== '0) $display("FAIL mid_rst_hits: got %h required 0", out_hits); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL mid_rst_cfg_ready: got %b required 1", cfg_ready); else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_pulse%0d: got %b required 0", c, out_valid); else passed++;
        end
        run_vec(26'h7, z, h);
        total++; if (z !== 11'h000) $display("FAIL mid_rst_cleared: got %h required 000", z); else passed++;
    endtask

    initial begin
        test_reset();
        test_no_config();
        test_single_term();
        test_polarity();
        test_back_to_back();
        test_cfg_stall();
        test_espresso();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
